// File: rtl/multicycle_control_fsm.sv
//------------------------------------------------------------------------------
// Module   : multicycle_control_fsm
// Purpose  : Multicycle control unit for the 16-bit CPE142 processor. Walks each
//            instruction through FETCH/DECODE/EXEC/MEM/WB, drives the datapath
//            enables and mux selects, guards memory accesses with a watchdog
//            and parks the machine in HALT on a HALT opcode or memory timeout.
// Ports    : clk, rst (async, active-high)
//            opcode[3:0], branch_cond, mem_ready        - inputs
//            pc_write, pc_src[1:0], ir_write, mem_read,
//            mem_write, reg_write, alu_src, mem_to_reg,
//            ext_sel                                    - datapath controls
//            state[2:0], halted, mem_fault, illegal_op  - status / debug
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control_fsm #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       branch_cond,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic       ext_sel,
  output logic [2:0] state,
  output logic       halted,
  output logic       mem_fault,
  output logic       illegal_op
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Fault fires in the stall cycle that would bring the counter to TIMEOUT.
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wd_q;
  logic       fault_q;

  // Opcode classes
  logic is_rtype, is_imm, is_branch, is_lw, is_sw, is_jmp, is_halt, is_legal;
  assign is_rtype  = (opcode == 4'b0000);
  assign is_imm    = (opcode == 4'b0001) || (opcode == 4'b0010) || (opcode == 4'b0011);
  assign is_branch = (opcode == 4'b0100) || (opcode == 4'b0101) || (opcode == 4'b0110);
  assign is_lw     = (opcode == 4'b1000);
  assign is_sw     = (opcode == 4'b1011);
  assign is_jmp    = (opcode == 4'b1100);
  assign is_halt   = (opcode == 4'b1111);
  assign is_legal  = is_rtype | is_imm | is_branch | is_lw | is_sw | is_jmp | is_halt;

  // mem_ready only matters while a memory access is outstanding.
  logic stall, timeout_hit;
  assign stall       = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
  assign timeout_hit = stall && (wd_q == WD_LIMIT);

  // State register, watchdog and sticky fault flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      wd_q    <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Any non-stall cycle (completion, or any other state) zeroes the
      // counter, so every entry into FETCH/MEM starts from 0.
      wd_q    <= stall ? wd_q + 8'd1 : 8'd0;
      if (timeout_hit) fault_q <= 1'b1;
    end
  end

  // Raw controls before the reset gate
  logic       pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c;
  logic       alu_src_c, mem_to_reg_c, ext_sel_c, halted_c, illegal_c;
  logic [1:0] pc_src_c;

  always_comb begin
    state_d      = state_q;
    pc_write_c   = 1'b0;
    pc_src_c     = 2'b00;
    ir_write_c   = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    ext_sel_c    = 1'b0;
    halted_c     = 1'b0;
    illegal_c    = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (timeout_hit) begin
          state_d = S_HALT;
        end else begin
          mem_read_c = 1'b1;
          if (mem_ready) begin
            ir_write_c = 1'b1;
            pc_write_c = 1'b1;
            pc_src_c   = 2'b00;
            state_d    = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        ext_sel_c = is_jmp;
        if (!is_legal) begin
          illegal_c = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        ext_sel_c = is_jmp;
        alu_src_c = is_imm | is_lw | is_sw;
        if (is_rtype || is_imm) begin
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          pc_write_c = branch_cond;
          pc_src_c   = 2'b01;
          state_d    = S_FETCH;
        end else if (is_jmp) begin
          pc_write_c = 1'b1;
          pc_src_c   = 2'b10;
          state_d    = S_FETCH;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (timeout_hit) begin
          state_d = S_HALT;
        end else begin
          mem_read_c  = is_lw;
          mem_write_c = is_sw;
          if (mem_ready) state_d = is_lw ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = is_lw;
        state_d      = S_FETCH;
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // rst gates every output combinationally so no partial write can escape
  // in the cycle reset is raised.
  assign pc_write   = pc_write_c   & ~rst;
  assign pc_src     = pc_src_c     & {2{~rst}};
  assign ir_write   = ir_write_c   & ~rst;
  assign mem_read   = mem_read_c   & ~rst;
  assign mem_write  = mem_write_c  & ~rst;
  assign reg_write  = reg_write_c  & ~rst;
  assign alu_src    = alu_src_c    & ~rst;
  assign mem_to_reg = mem_to_reg_c & ~rst;
  assign ext_sel    = ext_sel_c    & ~rst;
  assign state      = state_q      & {3{~rst}};
  assign halted     = halted_c     & ~rst;
  assign mem_fault  = fault_q      & ~rst;
  assign illegal_op = illegal_c    & ~rst;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none

module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       branch_cond;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write, mem_read, mem_write, reg_write, alu_src, mem_to_reg, ext_sel;
  logic [2:0] state;
  logic       halted, mem_fault, illegal_op;

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .branch_cond(branch_cond),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .ext_sel    (ext_sel),
    .state      (state),
    .halted     (halted),
    .mem_fault  (mem_fault),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Compare every output at once, 1 ns after inputs were set.
  // Vector order: pw ps[1:0] irw mr mw rw as m2r es st[2:0] h mf il
  task automatic E(input string tag, input logic pw, input logic [1:0] ps,
                   input logic irw, input logic mr, input logic mw, input logic rw,
                   input logic as_, input logic m2r, input logic es,
                   input logic [2:0] st, input logic h, input logic mf, input logic il);
    logic [15:0] got, exp;
    #1;
    got = {pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, alu_src,
           mem_to_reg, ext_sel, state, halted, mem_fault, illegal_op};
    exp = {pw, ps, irw, mr, mw, rw, as_, m2r, es, st, h, mf, il};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; opcode = 4'b0000; branch_cond = 1'b0; mem_ready = 1'b1;
    #2;
    //        tag            pw ps    irw mr mw rw as m2r es st h mf il
    E("reset_all0",          0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    rst = 1'b0;

    // ADDI: 0,1,2,4 then back to 0
    opcode = 4'b0001;
    E("addi_fetch",          1, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); E("addi_decode",  0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(); E("addi_exec",    0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0);
    cyc(); E("addi_wb",      0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 4, 0, 0, 0);

    // LW with three wait cycles in MEM; the 4th MEM cycle is the watchdog
    // boundary, where mem_ready must win.
    cyc(); opcode = 4'b1000;
    E("lw_fetch",            1, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); E("lw_decode",    0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(); E("lw_exec",      0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0);
    cyc(); mem_ready = 1'b0;
    E("lw_mem_w1",           0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    cyc(); E("lw_mem_w2",    0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    cyc(); E("lw_mem_w3",    0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    cyc(); mem_ready = 1'b1;
    E("lw_mem_done",         0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    cyc(); E("lw_wb",        0, 2'd0, 0, 0, 0, 1, 0, 1, 0, 4, 0, 0, 0);

    // BEQ not taken, then taken
    cyc(); opcode = 4'b0110; branch_cond = 1'b0;
    E("beq0_fetch",          1, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); E("beq0_decode",  0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(); E("beq0_exec",    0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    cyc(); branch_cond = 1'b1;
    E("beq1_fetch",          1, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); E("beq1_decode",  0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(); E("beq1_exec",    1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);

    // JMP
    cyc(); opcode = 4'b1100; branch_cond = 1'b0;
    E("jmp_fetch",           1, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); E("jmp_decode",   0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    cyc(); E("jmp_exec",     1, 2'd2, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);

    // Illegal opcode 0111: one-cycle pulse in DECODE, then FETCH
    cyc(); opcode = 4'b0111;
    E("ill_fetch",           1, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); E("ill_decode",   0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    cyc(); E("ill_refetch",  1, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // SW stalled in MEM, reset mid-access
    opcode = 4'b1011;
    cyc(); E("sw_decode",    0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(); E("sw_exec",      0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0);
    cyc(); mem_ready = 1'b0;
    E("sw_mem",              0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0);
    rst = 1'b1;
    E("sw_rst_drop",         0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); rst = 1'b0; mem_ready = 1'b1;
    E("sw_rst_fetch",        1, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ADDI reset in WB
    opcode = 4'b0001;
    cyc(); cyc(); cyc();
    E("wb_before_rst",       0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 4, 0, 0, 0);
    rst = 1'b1;
    E("wb_rst_drop",         0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); rst = 1'b0;

    // Watchdog: FETCH stalled with TIMEOUT = 4
    mem_ready = 1'b0;
    E("to_stall1",           0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); E("to_stall2",    0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); E("to_stall3",    0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); #1; chk1("to_stall4_state", state, 3'd0);
    cyc(); E("to_halted",    0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 1, 0);
    mem_ready = 1'b1;
    cyc(); E("to_halt_hold", 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 1, 0);
    rst = 1'b1;
    E("to_rst_clear",        0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); rst = 1'b0;

    // HALT opcode: stays halted until reset
    opcode = 4'b1111;
    E("hlt_fetch",           1, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); E("hlt_decode",   0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(); E("hlt_exec",     0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    cyc(); E("hlt_state",    0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0);
    opcode = 4'b0001;
    cyc(); cyc();
    E("hlt_hold",            0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0);
    rst = 1'b1;
    E("hlt_rst",             0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); rst = 1'b0;
    E("hlt_rst_fetch",       1, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
